// File: rtl/ifu_fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package ysyx_ifu_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_RESP,
        S_OUT,
        S_NPC
    } ifu_state_e;

    localparam logic [1:0]  RESP_OKAY        = 2'b00;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h8000_0000;

endpackage

// File: rtl/ifu_fetch.sv
// Instruction fetch stage: owns the PC, issues one AR/R read per instruction
// and hands the word to decode, then waits for the next PC from write-back.
module ifu_fetch
    import ysyx_ifu_pkg::*;
#(
    parameter int unsigned      WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(DEFAULT_RESET_PC)
) (
    input  logic             clk,
    input  logic             rst,
    output logic [WIDTH-1:0] araddr,
    output logic             arvalid,
    input  logic             arready,
    input  logic [31:0]      rdata,
    input  logic [1:0]       rresp,
    input  logic             rvalid,
    output logic             rready,
    output logic [31:0]      inst,
    output logic [WIDTH-1:0] inst_pc,
    output logic             inst_fault,
    output logic             inst_valid,
    input  logic             inst_ready,
    input  logic [WIDTH-1:0] npc,
    input  logic             npc_valid,
    output logic [WIDTH-1:0] pc
);

    ifu_state_e       r_state;
    ifu_state_e       w_state_next;
    logic [WIDTH-1:0] r_pc;
    logic [31:0]      r_inst;
    logic [WIDTH-1:0] r_inst_pc;
    logic             r_inst_fault;
    logic             w_npc_misaligned;

    assign w_npc_misaligned = (npc[1:0] != 2'b00);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: w_state_next = S_REQ;
            S_REQ:  if (arready)    w_state_next = S_RESP;
            S_RESP: if (rvalid)     w_state_next = S_OUT;
            S_OUT:  if (inst_ready) w_state_next = S_NPC;
            S_NPC: begin
                // A misaligned target never reaches the bus; it is reported as a fault directly.
                if (npc_valid) begin
                    w_state_next = w_npc_misaligned ? S_OUT : S_REQ;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        arvalid    = 1'b0;
        rready     = 1'b0;
        inst_valid = 1'b0;
        case (r_state)
            S_REQ:   arvalid    = 1'b1;
            S_RESP:  rready     = 1'b1;
            S_OUT:   inst_valid = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc         <= RESET_PC;
            r_inst       <= '0;
            r_inst_pc    <= RESET_PC;
            r_inst_fault <= 1'b0;
        end else begin
            if (r_state == S_RESP && rvalid) begin
                r_inst       <= rdata;
                r_inst_pc    <= r_pc;
                r_inst_fault <= (rresp != RESP_OKAY);
            end
            if (r_state == S_NPC && npc_valid) begin
                r_pc <= npc;
                if (w_npc_misaligned) begin
                    r_inst       <= '0;
                    r_inst_pc    <= npc;
                    r_inst_fault <= 1'b1;
                end
            end
        end
    end

    assign araddr     = r_pc;
    assign pc         = r_pc;
    assign inst       = r_inst;
    assign inst_pc    = r_inst_pc;
    assign inst_fault = r_inst_fault;

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed and randomized checks of ifu_fetch against a transaction-level
// model: a sparse random memory keyed by address plus the expected PC.
module tb_ifu_fetch;

    localparam logic [31:0] RPC = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_fault;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] npc;
    logic        npc_valid;
    logic [31:0] pc;

    int n_checks = 0;
    int n_errors = 0;
    int n_ar     = 0;

    logic [31:0] mem    [logic [31:0]];
    logic        errmap [logic [31:0]];

    ifu_fetch #(.WIDTH(32), .RESET_PC(RPC)) dut (
        .clk        (clk),
        .rst        (rst),
        .araddr     (araddr),
        .arvalid    (arvalid),
        .arready    (arready),
        .rdata      (rdata),
        .rresp      (rresp),
        .rvalid     (rvalid),
        .rready     (rready),
        .inst       (inst),
        .inst_pc    (inst_pc),
        .inst_fault (inst_fault),
        .inst_valid (inst_valid),
        .inst_ready (inst_ready),
        .npc        (npc),
        .npc_valid  (npc_valid),
        .pc         (pc)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (arvalid === 1'b1 && arready === 1'b1) n_ar <= n_ar + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Lazily populated memory contents and per-address bus-error flag.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (!mem.exists(a)) begin
            mem[a]    = $urandom;
            errmap[a] = ($urandom_range(0, 3) == 0);
        end
        return mem[a];
    endfunction

    function automatic logic mem_err(input logic [31:0] a);
        void'(mem_word(a));
        return errmap[a];
    endfunction

    initial begin
        int          base;
        logic [31:0] exp_pc;
        logic [31:0] a;
        logic [31:0] req;
        logic [31:0] exp_inst;
        logic        exp_fault;

        rst = 1'b1; arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = 2'b00;
        inst_ready = 1'b0; npc = '0; npc_valid = 1'b0;
        tick();
        tick();
        check("rst_arvalid", 32'(arvalid), 32'd0);
        check("rst_rready", 32'(rready), 32'd0);
        check("rst_inst_valid", 32'(inst_valid), 32'd0);
        check("rst_pc", pc, RPC);
        check("rst_inst", inst, 32'h0);
        check("rst_inst_pc", inst_pc, RPC);
        check("rst_inst_fault", 32'(inst_fault), 32'd0);

        // Zero-wait memory after reset release.
        rst = 1'b0;
        base = n_ar;
        arready = 1'b1; rvalid = 1'b1; rdata = 32'h0000_0413; rresp = 2'b00;
        check("idle_arvalid", 32'(arvalid), 32'd0);
        tick();
        check("c1_arvalid", 32'(arvalid), 32'd1);
        check("c1_araddr", araddr, RPC);
        tick();
        check("c2_rready", 32'(rready), 32'd1);
        check("c2_inst_valid", 32'(inst_valid), 32'd0);
        tick();
        check("c3_inst_valid", 32'(inst_valid), 32'd1);
        check("c3_inst", inst, 32'h0000_0413);
        check("c3_inst_pc", inst_pc, RPC);
        check("c3_inst_fault", 32'(inst_fault), 32'd0);
        check("c3_ar_count", 32'(n_ar - base), 32'd1);
        arready = 1'b0; rvalid = 1'b0;
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
        check("npc_wait_inst_valid", 32'(inst_valid), 32'd0);
        check("npc_wait_arvalid", 32'(arvalid), 32'd0);

        // arready held low 3 cycles; rvalid held high while in REQ must be ignored.
        npc = RPC; npc_valid = 1'b1;
        rvalid = 1'b1; rdata = 32'hDEAD_BEEF; rresp = 2'b10;
        tick();
        npc_valid = 1'b0;
        base = n_ar;
        for (int i = 0; i < 3; i++) begin
            check("stall_arvalid", 32'(arvalid), 32'd1);
            check("stall_araddr", araddr, RPC);
            tick();
        end
        check("stall_arvalid", 32'(arvalid), 32'd1);
        check("stall_araddr", araddr, RPC);
        arready = 1'b1;
        tick();
        arready = 1'b0;
        check("stall_ar_count", 32'(n_ar - base), 32'd1);
        check("nocollapse_rready", 32'(rready), 32'd1);
        check("nocollapse_inst_valid", 32'(inst_valid), 32'd0);
        tick();
        rvalid = 1'b0; rresp = 2'b00;
        check("err_inst_valid", 32'(inst_valid), 32'd1);
        check("err_inst", inst, 32'hDEAD_BEEF);
        check("err_inst_fault", 32'(inst_fault), 32'd1);
        check("err_inst_pc", inst_pc, RPC);

        // Decode back-pressure with stray npc pulses.
        npc = 32'h1234_5678; npc_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("hold_inst_valid", 32'(inst_valid), 32'd1);
            check("hold_inst", inst, 32'hDEAD_BEEF);
            check("hold_inst_pc", inst_pc, RPC);
            check("hold_pc", pc, RPC);
        end
        npc_valid = 1'b0;
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;

        // Misaligned target faults without a bus request.
        npc = 32'h8000_0006; npc_valid = 1'b1;
        tick();
        npc_valid = 1'b0;
        check("mis_arvalid", 32'(arvalid), 32'd0);
        check("mis_inst_valid", 32'(inst_valid), 32'd1);
        check("mis_inst", inst, 32'h0);
        check("mis_inst_pc", inst_pc, 32'h8000_0006);
        check("mis_inst_fault", 32'(inst_fault), 32'd1);
        check("mis_pc", pc, 32'h8000_0006);
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
        npc = 32'h8000_0010; npc_valid = 1'b1;
        tick();
        npc_valid = 1'b0;
        check("al_arvalid", 32'(arvalid), 32'd1);
        check("al_araddr", araddr, 32'h8000_0010);

        // Reset while waiting for the response.
        arready = 1'b1;
        tick();
        arready = 1'b0;
        check("pre_rst_rready", 32'(rready), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_arvalid", 32'(arvalid), 32'd0);
        check("mid_rst_rready", 32'(rready), 32'd0);
        check("mid_rst_inst_valid", 32'(inst_valid), 32'd0);
        check("mid_rst_pc", pc, RPC);
        tick();
        check("post_rst_arvalid", 32'(arvalid), 32'd1);
        check("post_rst_araddr", araddr, RPC);
        arready = 1'b1;
        tick();
        arready = 1'b0;
        rvalid = 1'b1; rdata = 32'h0000_0013; rresp = 2'b00;
        tick();
        rvalid = 1'b0;
        check("post_rst_inst", inst, 32'h0000_0013);
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
        exp_pc = RPC;

        // Randomized transactions against the memory model.
        for (int t = 0; t < 60; t++) begin
            a = RPC + ($urandom_range(0, 63) << 2);
            if ($urandom_range(0, 7) == 0) a = 32'hFFFF_FFFC;
            if ($urandom_range(0, 3) == 0) a = a | 32'($urandom_range(1, 3));
            for (int i = 0; i < int'($urandom_range(0, 2)); i++) begin
                tick();
                check("rnd_idle_pc", pc, exp_pc);
            end
            npc = a; npc_valid = 1'b1;
            tick();
            npc_valid = 1'b0; npc = $urandom;
            exp_pc = a;
            check("rnd_pc", pc, exp_pc);
            if (a[1:0] != 2'b00) begin
                exp_inst  = 32'h0;
                exp_fault = 1'b1;
                check("rnd_mis_arvalid", 32'(arvalid), 32'd0);
            end else begin
                exp_inst  = mem_word(a);
                exp_fault = mem_err(a);
                base = n_ar;
                for (int i = 0; i < int'($urandom_range(0, 3)); i++) begin
                    check("rnd_stall_arvalid", 32'(arvalid), 32'd1);
                    check("rnd_stall_araddr", araddr, a);
                    tick();
                end
                check("rnd_arvalid", 32'(arvalid), 32'd1);
                check("rnd_araddr", araddr, a);
                req = araddr;
                arready = 1'b1;
                tick();
                arready = 1'b0;
                check("rnd_ar_count", 32'(n_ar - base), 32'd1);
                for (int i = 0; i < int'($urandom_range(0, 3)); i++) begin
                    check("rnd_rready", 32'(rready), 32'd1);
                    check("rnd_resp_inst_valid", 32'(inst_valid), 32'd0);
                    tick();
                end
                rdata = mem_word(req);
                rresp = mem_err(req) ? 2'($urandom_range(1, 3)) : 2'b00;
                rvalid = 1'b1;
                tick();
                rvalid = 1'b0; rdata = $urandom; rresp = 2'($urandom);
            end
            check("rnd_inst_valid", 32'(inst_valid), 32'd1);
            check("rnd_inst", inst, exp_inst);
            check("rnd_inst_pc", inst_pc, a);
            check("rnd_inst_fault", 32'(inst_fault), 32'(exp_fault));
            for (int i = 0; i < int'($urandom_range(0, 3)); i++) begin
                npc = $urandom; npc_valid = $urandom_range(0, 1) == 1;
                tick();
                check("rnd_hold_inst_valid", 32'(inst_valid), 32'd1);
                check("rnd_hold_inst", inst, exp_inst);
                check("rnd_hold_pc", pc, exp_pc);
            end
            npc_valid = 1'b0;
            inst_ready = 1'b1;
            tick();
            inst_ready = 1'b0;
            check("rnd_accept_inst_valid", 32'(inst_valid), 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
